// File: rtl/serial_adder_controller_if.sv
// Handshake and operand/result bundle for the serial adder controller.
// master drives the request (start/subtract/a/b); slave returns status and results.
// WIDTH must match the controller's WIDTH.
interface serial_adder_controller_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             subtract;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;

  modport master (
    output start, subtract, a, b,
    input  busy, done, sum, carryout, overflow
  );

  modport slave (
    input  start, subtract, a, b,
    output busy, done, sum, carryout, overflow
  );
endinterface

// File: rtl/serial_adder_controller.sv
// Bit-serial WIDTH-bit add/subtract built around one 1-bit full adder, LSB first.
// Latency: start sampled at E0, done pulses after edge E0+WIDTH; results held until the next completion.
// Backpressure: none; start is only honoured in IDLE/DONE and ignored while busy.
module serial_adder_controller #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                reset,
  serial_adder_controller_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    count;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             fa_s;
  logic             fa_c;
  logic             last;

  // The single shared full adder cell; carry holds the carry into the current bit.
  assign fa_s = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_c = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign last = (count == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and status outputs; DONE accepts a new start directly for back-to-back issue.
  always_comb begin
    state_nx = state;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nx = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = bus.start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, serial shift datapath and result registers updated only on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      carry        <= 1'b0;
      a_sh         <= '0;
      b_sh         <= '0;
      s_sh         <= '0;
      bus.sum      <= '0;
      bus.carryout <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            a_sh  <= bus.a;
            b_sh  <= bus.subtract ? ~bus.b : bus.b;
            carry <= bus.subtract;
            count <= '0;
          end
        end
        RUN: begin
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          s_sh  <= {fa_s, s_sh[WIDTH-1:1]};
          carry <= fa_c;
          count <= count + CW'(1);
          if (last) begin
            // On the MSB step carry is the carry into the MSB, so cout ^ carry is signed overflow.
            bus.sum      <= {fa_s, s_sh[WIDTH-1:1]};
            bus.carryout <= fa_c;
            bus.overflow <= fa_c ^ carry;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
